mpmc11_rd_burst_sched: RTL and testbench

Round-robin read-burst scheduler for the mpmc11 read path. It shares the single memory read-command/response channel among NCH requesting ports. It selects one port, issues that port's burst command, and counts the returning response beats. It tags each beat with the owning channel and the last-beat flag, and supervises the burst with a no-progress watchdog. It sits between the per-port request FIFOs and the memory PHY command interface, and replaces ad-hoc state/valid sequencing around the response beat counter.

---
 rtl/mpmc11_rd_burst_sched.sv | 144 ++++++++++++++
 tb/tb_mpmc11_rd_burst_sched.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mpmc11_rd_burst_sched.sv
// rtl/mpmc11_rd_burst_sched.sv - round-robin read-burst scheduler with beat counter and watchdog
module mpmc11_rd_burst_sched #(
    parameter int NCH     = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NCH-1:0]             req,
    input  logic [NCH*32-1:0]          req_adr,
    input  logic [NCH*8-1:0]           req_len,
    output logic [NCH-1:0]             grant,
    output logic                       cmd_valid,
    input  logic                       cmd_rdy,
    output logic [31:0]                cmd_adr,
    output logic [7:0]                 cmd_len,
    input  logic                       rsp_valid,
    output logic [$clog2(NCH)-1:0]     rsp_ch,
    output logic [7:0]                 rsp_beat,
    output logic                       rsp_last,
    output logic                       busy,
    output logic                       err
);

    localparam int CW = $clog2(NCH);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, CMD, READ_DATA, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   rr_q, rr_d;
    logic [CW-1:0]   ch_q, ch_d;
    logic [NCH-1:0]  grant_q, grant_d;
    logic [31:0]     adr_q, adr_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      beat_q, beat_d;
    logic [WW-1:0]   wd_q, wd_d;
    logic [CW-1:0]   sel;
    logic [CW:0]     idx;
    logic            found;
    logic            wd_expire;

    // First requester at or after rr_q, wrapping modulo NCH.
    always_comb begin
        sel   = rr_q;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = {1'b0, rr_q} + (CW+1)'(k);
            if (idx >= (CW+1)'(NCH)) begin
                idx = idx - (CW+1)'(NCH);
            end
            if (!found && req[idx[CW-1:0]]) begin
                found = 1'b1;
                sel   = idx[CW-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        ch_d      = ch_q;
        grant_d   = '0;
        adr_d     = adr_q;
        len_d     = len_q;
        beat_d    = beat_q;
        wd_d      = wd_q;
        wd_expire = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = NCH'(1) << sel;
                    adr_d   = req_adr[32*int'(sel) +: 32];
                    len_d   = req_len[8*int'(sel) +: 8];
                    ch_d    = sel;
                    rr_d    = (sel == CW'(NCH-1)) ? '0 : sel + 1'b1;
                    state_d = CMD;
                end
            end
            CMD: begin
                if (cmd_rdy) begin
                    beat_d  = '0;
                    wd_d    = '0;
                    state_d = READ_DATA;
                end
            end
            READ_DATA: begin
                // A beat on the would-be expiry cycle wins over the abort.
                if (rsp_valid) begin
                    wd_d = '0;
                    if (beat_q == len_q) begin
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end else if (wd_q == WW'(TIMEOUT-1)) begin
                    wd_expire = 1'b1;
                    state_d   = DONE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            ch_q    <= '0;
            grant_q <= '0;
            adr_q   <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            ch_q    <= ch_d;
            grant_q <= grant_d;
            adr_q   <= adr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            wd_q    <= wd_d;
        end
    end

    assign grant     = grant_q;
    assign cmd_valid = (state_q == CMD);
    assign cmd_adr   = adr_q;
    assign cmd_len   = len_q;
    assign rsp_ch    = ch_q;
    assign rsp_beat  = beat_q;
    assign rsp_last  = (state_q == READ_DATA) && rsp_valid && (beat_q == len_q);
    assign busy      = (state_q != IDLE);
    assign err       = wd_expire && !rst;

endmodule

// File: tb/tb_mpmc11_rd_burst_sched.sv
// tb/tb_mpmc11_rd_burst_sched.sv - randomized self-checking bench for mpmc11_rd_burst_sched
module tb_mpmc11_rd_burst_sched;

    localparam int NCH = 4;
    localparam int TO  = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req = '0;
    logic [127:0] req_adr = '0;
    logic [31:0]  req_len = '0;
    logic [3:0]   grant;
    logic         cmd_valid;
    logic         cmd_rdy = 1'b0;
    logic [31:0]  cmd_adr;
    logic [7:0]   cmd_len;
    logic         rsp_valid = 1'b0;
    logic [1:0]   rsp_ch;
    logic [7:0]   rsp_beat;
    logic         rsp_last;
    logic         busy;
    logic         err;

    int checks = 0;
    int errors = 0;
    int rr_m   = 0;

    mpmc11_rd_burst_sched #(.NCH(NCH), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_adr(req_adr), .req_len(req_len),
        .grant(grant), .cmd_valid(cmd_valid), .cmd_rdy(cmd_rdy), .cmd_adr(cmd_adr),
        .cmd_len(cmd_len), .rsp_valid(rsp_valid), .rsp_ch(rsp_ch), .rsp_beat(rsp_beat),
        .rsp_last(rsp_last), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, exp finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin model: first requester at or after the pointer, modulo NCH.
    function automatic int pick(input logic [3:0] mask);
        for (int k = 0; k < NCH; k++) begin
            if (mask[(rr_m + k) % NCH]) return (rr_m + k) % NCH;
        end
        return -1;
    endfunction

    // Starts in an IDLE cycle, ends in the following IDLE cycle.
    task automatic burst(input logic [3:0] rmask, input int len, input int rdy_wait,
                         input int gap, input bit rand_gap, input int stop_after, input bit keep_req);
        int ch, b, g;
        logic [31:0] eadr;
        logic [3:0]  eg;
        ch = pick(rmask);
        for (int i = 0; i < NCH; i++) begin
            req_adr[32*i +: 32] = $urandom;
            req_len[8*i +: 8]   = (i == ch) ? len[7:0] : 8'($urandom);
        end
        eadr = req_adr[32*ch +: 32];
        eg   = 4'b0001 << ch;
        req = rmask; cmd_rdy = 1'b0; rsp_valid = 1'b0;
        tick();
        req = keep_req ? rmask : 4'b0000;
        req_adr = {$urandom, $urandom, $urandom, $urandom};
        req_len = $urandom;
        rr_m = (ch + 1) % NCH;
        cmd_rdy = (rdy_wait == 0);
        #1;
        checks++; if (grant !== eg) begin errors++; $display("FAIL grant: got %b exp %b", grant, eg); end
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL cmd_valid: got %b exp 1", cmd_valid); end
        checks++; if (cmd_adr !== eadr) begin errors++; $display("FAIL cmd_adr: got %h exp %h", cmd_adr, eadr); end
        checks++; if (cmd_len !== len[7:0]) begin errors++; $display("FAIL cmd_len: got %0d exp %0d", cmd_len, len); end
        checks++; if (rsp_ch !== ch[1:0]) begin errors++; $display("FAIL rsp_ch_grant: got %0d exp %0d", rsp_ch, ch); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_cmd: got %b exp 1", busy); end
        for (int w = 1; w <= rdy_wait; w++) begin
            tick();
            cmd_rdy = (w == rdy_wait);
            rsp_valid = 1'($urandom);
            #1;
            checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL grant_pulse: got %b exp 0000", grant); end
            checks++; if (cmd_valid !== 1'b1 || cmd_adr !== eadr || cmd_len !== len[7:0])
                begin errors++; $display("FAIL cmd_stable: got v=%b a=%h l=%0d exp v=1 a=%h l=%0d", cmd_valid, cmd_adr, cmd_len, eadr, len); end
            checks++; if (rsp_last !== 1'b0) begin errors++; $display("FAIL rsp_last_cmd: got %b exp 0", rsp_last); end
        end
        tick();
        cmd_rdy = 1'b0;
        b = 0;
        while (b <= len) begin
            if (stop_after >= 0 && b > stop_after) break;
            g = rand_gap ? $urandom_range(gap, 0) : gap;
            for (int s = 0; s < g; s++) begin
                rsp_valid = 1'b0;
                #1;
                checks++; if (err !== 1'b0 || rsp_last !== 1'b0 || cmd_valid !== 1'b0)
                    begin errors++; $display("FAIL gap: got err=%b last=%b cv=%b exp 0 0 0", err, rsp_last, cmd_valid); end
                tick();
            end
            rsp_valid = 1'b1;
            #1;
            checks++; if (rsp_beat !== 8'(b)) begin errors++; $display("FAIL rsp_beat: got %0d exp %0d", rsp_beat, b); end
            checks++; if (rsp_ch !== ch[1:0]) begin errors++; $display("FAIL rsp_ch: got %0d exp %0d", rsp_ch, ch); end
            checks++; if (rsp_last !== (b == len)) begin errors++; $display("FAIL rsp_last: got %b exp %b beat %0d", rsp_last, (b == len), b); end
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_beat: got %b exp 0", err); end
            tick();
            b++;
        end
        rsp_valid = 1'b0;
        if (stop_after >= 0) begin
            for (int s = 1; s <= TO; s++) begin
                #1;
                checks++; if (err !== (s == TO)) begin errors++; $display("FAIL err_timing: got %b exp %b quiet %0d", err, (s == TO), s); end
                tick();
            end
        end
        #1;
        checks++; if (busy !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL done: got busy=%b err=%b exp 1 0", busy, err); end
        if (stop_after < 0) begin
            checks++; if (rsp_beat !== len[7:0]) begin errors++; $display("FAIL beat_hold: got %0d exp %0d", rsp_beat, len); end
        end
        tick();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b exp 0", busy); end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'hF; cmd_rdy = 1'b1; rsp_valid = 1'b1;
        repeat (3) tick();
        #1;
        checks++; if (grant !== 4'b0000 || cmd_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0)
            begin errors++; $display("FAIL reset_ctl: got g=%b cv=%b busy=%b err=%b exp all 0", grant, cmd_valid, busy, err); end
        checks++; if (cmd_adr !== 32'd0 || cmd_len !== 8'd0 || rsp_ch !== 2'd0 || rsp_beat !== 8'd0 || rsp_last !== 1'b0)
            begin errors++; $display("FAIL reset_data: got a=%h l=%0d ch=%0d b=%0d last=%b exp all 0", cmd_adr, cmd_len, rsp_ch, rsp_beat, rsp_last); end
        req = '0; cmd_rdy = 1'b0; rsp_valid = 1'b0; rst = 1'b0;
        rr_m = 0;
        tick();
    endtask

    task automatic test_fairness();
        for (int n = 0; n < 5; n++) burst(4'hF, 0, 0, 0, 1'b0, -1, 1'b1);
        req = '0;
    endtask

    task automatic test_single();
        burst(4'b0100, 3, 0, 0, 1'b0, -1, 1'b0);
    endtask

    task automatic test_cmd_stall();
        burst(4'($urandom_range(15, 1)), $urandom_range(3, 0), 10, 0, 1'b0, -1, 1'b0);
    endtask

    task automatic test_timeout();
        burst(4'b0010, 3, 0, 0, 1'b0, 1, 1'b0);
        rsp_valid = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1;
            checks++; if (busy !== 1'b0 || rsp_last !== 1'b0 || err !== 1'b0)
                begin errors++; $display("FAIL stray: got busy=%b last=%b err=%b exp 0 0 0", busy, rsp_last, err); end
            tick();
        end
        #1;
        checks++; if (rsp_beat !== 8'd2) begin errors++; $display("FAIL stray_count: got %0d exp 2", rsp_beat); end
        rsp_valid = 1'b0;
    endtask

    task automatic test_long_and_edge();
        burst(4'($urandom_range(15, 1)), 255, 0, 2, 1'b0, -1, 1'b0);
        burst(4'($urandom_range(15, 1)), 2, 0, TO - 1, 1'b0, -1, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++)
            burst(4'($urandom_range(15, 1)), $urandom_range(15, 0), $urandom_range(3, 0), TO - 1, 1'b1, -1, 1'b0);
    endtask

    task automatic test_reset_mid();
        req_len = {4{8'd15}};
        req = 4'b0010; tick();
        req = '0; cmd_rdy = 1'b1; tick();
        cmd_rdy = 1'b0;
        for (int b = 0; b < 5; b++) begin
            rsp_valid = 1'b1; #1;
            checks++; if (rsp_beat !== 8'(b)) begin errors++; $display("FAIL mid_beat: got %0d exp %0d", rsp_beat, b); end
            tick();
        end
        rst = 1'b1; tick();
        rst = 1'b0; #1;
        checks++; if (grant !== 4'b0000 || cmd_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || rsp_last !== 1'b0)
            begin errors++; $display("FAIL mid_reset_ctl: got g=%b cv=%b busy=%b err=%b last=%b exp all 0", grant, cmd_valid, busy, err, rsp_last); end
        checks++; if (cmd_adr !== 32'd0 || cmd_len !== 8'd0 || rsp_ch !== 2'd0 || rsp_beat !== 8'd0)
            begin errors++; $display("FAIL mid_reset_data: got a=%h l=%0d ch=%0d b=%0d exp all 0", cmd_adr, cmd_len, rsp_ch, rsp_beat); end
        rsp_valid = 1'b0;
        rr_m = 0;
        burst(4'b1010, 4, 0, 1, 1'b1, -1, 1'b0);
        burst(4'b1000, 2, 1, 0, 1'b0, -1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_single();
        test_cmd_stall();
        test_timeout();
        test_long_and_edge();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
